// File: rtl/fsm_101_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_101_pkg
//  Description : Shared definitions for the "101"-sync serial link: one-hot
//                transmitter state encoding and the sync pattern used by
//                both the transmitter and the companion detector.
//  Revision    : 1.0  initial release
// ============================================================================
package fsm_101_pkg;

    // Width of the one-hot transmitter state vector.
    localparam int STATE_W = 5;

    // One-hot transmitter states. Any other value is treated as illegal.
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 5'b00001,
        SYNC0 = 5'b00010,
        SYNC1 = 5'b00100,
        SYNC2 = 5'b01000,
        DATA  = 5'b10000
    } state_t;

    // Sync pattern, sent MSB first ahead of every payload word.
    localparam logic [2:0] SYNC_PAT = 3'b101;

    // Sync bit for position idx (0 = first bit on the line).
    function automatic logic sync_bit(input int unsigned idx);
        logic [2:0] pat;
        pat = SYNC_PAT;
        return pat[2 - idx];
    endfunction

endpackage : fsm_101_pkg
`default_nettype wire

// File: rtl/fsm_101_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_101_frame_tx
//  Description : Frame transmitter for the "101"-sync serial link. Accepts a
//                parallel word over a val/rdy handshake and serializes it as
//                the sync pattern 1,0,1 followed by the payload, MSB first.
//  Revision    : 1.0  initial release
// ============================================================================
module fsm_101_frame_tx
    import fsm_101_pkg::*;
#(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in_msg,
    output logic             out,
    output logic             out_val,
    output logic             busy
);

    // Counter wide enough for 0..NBITS; the last data bit is at NBITS-1.
    localparam int                c_cnt_w    = $clog2(NBITS + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(NBITS - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [NBITS-1:0]   r_shreg;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_last;
    logic               w_acc;

    // Handshake qualifiers shared by the next-state and datapath logic.
    assign w_last = (r_cnt == c_cnt_last);
    assign w_acc  = in_val & in_rdy;

    // Next-state decode; anything not one-hot falls back to IDLE.
    always_comb begin
        w_state_next = IDLE;
        case (r_state)
            IDLE:    w_state_next = w_acc ? SYNC0 : IDLE;
            SYNC0:   w_state_next = SYNC1;
            SYNC1:   w_state_next = SYNC2;
            SYNC2:   w_state_next = DATA;
            DATA: begin
                if (!w_last)
                    w_state_next = DATA;
                else if (w_acc)
                    w_state_next = SYNC0;
                else
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state only; illegal states
    // drive the line quiet and refuse new words.
    always_comb begin
        out     = 1'b0;
        out_val = 1'b0;
        busy    = 1'b0;
        in_rdy  = 1'b0;
        case (r_state)
            IDLE: begin
                in_rdy = 1'b1;
            end
            SYNC0: begin
                out     = sync_bit(0);
                out_val = 1'b1;
                busy    = 1'b1;
            end
            SYNC1: begin
                out     = sync_bit(1);
                out_val = 1'b1;
                busy    = 1'b1;
            end
            SYNC2: begin
                out     = sync_bit(2);
                out_val = 1'b1;
                busy    = 1'b1;
            end
            DATA: begin
                out     = r_shreg[NBITS-1];
                out_val = 1'b1;
                busy    = 1'b1;
                // Ready on the last payload bit so frames run back to back.
                in_rdy  = w_last;
            end
            default: begin
                out     = 1'b0;
                out_val = 1'b0;
                busy    = 1'b0;
                in_rdy  = 1'b0;
            end
        endcase
    end

    // State register plus shift register and bit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (w_acc)
                        r_shreg <= in_msg;
                end
                SYNC2: begin
                    r_cnt <= '0;
                end
                DATA: begin
                    if (!w_last) begin
                        r_shreg <= r_shreg << 1;
                        r_cnt   <= r_cnt + c_cnt_w'(1);
                    end else if (w_acc) begin
                        r_shreg <= in_msg;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : fsm_101_frame_tx
`default_nettype wire

// File: tb/tb_fsm_101_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fsm_101_frame_tx
//  Description : Directed self-checking bench for fsm_101_frame_tx, with a
//                one-hot Moore "101" detector on the serial line.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fsm_101_frame_tx;

    localparam int NB = 8;

    logic          clk;
    logic          reset;
    logic          in_val;
    logic          in_rdy;
    logic [NB-1:0] in_msg;
    logic          out;
    logic          out_val;
    logic          busy;

    int vectors    = 0;
    int miscompares = 0;

    fsm_101_frame_tx #(.NBITS(NB)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_msg  (in_msg),
        .out     (out),
        .out_val (out_val),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver-side one-hot Moore "101" detector: D0 none, D1 "1",
    // D2 "10", D3 "101" (output high).
    logic [3:0] det_state;
    logic       det_out;
    assign det_out = det_state[3];

    // Detector state register, fed by the serial line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            det_state <= 4'b0001;
        else begin
            case (det_state)
                4'b0001: det_state <= out ? 4'b0010 : 4'b0001;
                4'b0010: det_state <= out ? 4'b0010 : 4'b0100;
                4'b0100: det_state <= out ? 4'b1000 : 4'b0001;
                4'b1000: det_state <= out ? 4'b0010 : 4'b0100;
                default: det_state <= 4'b0001;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the quiet idle line at the current sample point.
    task automatic chk_idle(input string tag);
        chk({tag, ".out"},     {31'd0, out},     32'd0);
        chk({tag, ".out_val"}, {31'd0, out_val}, 32'd0);
        chk({tag, ".busy"},    {31'd0, busy},    32'd0);
        chk({tag, ".in_rdy"},  {31'd0, in_rdy},  32'd1);
    endtask

    // Watch len serial cycles starting the cycle after the current one.
    // pat holds the expected bits, first bit at pat[len-1]. mask[i] drives
    // in_val during cycle i; nxt is placed on in_msg after the first cycle.
    // When chk_det is set, the detector must be high only in cycle det_at.
    task automatic watch(input string tag, input logic [31:0] pat, input int len,
                         input logic [31:0] mask, input logic [NB-1:0] nxt,
                         input bit chk_det, input int det_at);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            chk($sformatf("%s.out[%0d]", tag, i),     {31'd0, out},     {31'd0, pat[len-1-i]});
            chk($sformatf("%s.out_val[%0d]", tag, i), {31'd0, out_val}, 32'd1);
            chk($sformatf("%s.busy[%0d]", tag, i),    {31'd0, busy},    32'd1);
            chk($sformatf("%s.in_rdy[%0d]", tag, i),  {31'd0, in_rdy},
                {31'd0, ((i % (NB + 3)) == (NB + 2))});
            if (chk_det)
                chk($sformatf("%s.det[%0d]", tag, i), {31'd0, det_out}, {31'd0, (i == det_at)});
            in_val = mask[i];
            if (i == 0)
                in_msg = nxt;
        end
    endtask

    logic [31:0] pat;

    initial begin
        reset  = 1'b1;
        in_val = 1'b0;
        in_msg = '0;

        // Outputs while reset is held.
        @(negedge clk);
        @(negedge clk);
        chk_idle("in_reset");
        reset = 1'b0;

        // Idle for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle($sformatf("idle%0d", i));
        end

        // Single frame of 8'hA5.
        in_val = 1'b1;
        in_msg = 8'hA5;
        pat = {21'd0, 3'b101, 8'hA5};
        watch("a5", pat, 11, 32'h0, 8'h00, 1'b0, 0);
        @(negedge clk);
        chk_idle("a5_after");

        // Back-to-back 8'hFF then 8'h00 with in_val held across the boundary.
        in_val = 1'b1;
        in_msg = 8'hFF;
        pat = {10'd0, 3'b101, 8'hFF, 3'b101, 8'h00};
        watch("b2b", pat, 22, 32'h0000_07FF, 8'h00, 1'b0, 0);
        @(negedge clk);
        chk_idle("b2b_after");

        // Pulses in SYNC1 and DATA cnt=3 ignored; word taken on last data bit.
        in_val = 1'b1;
        in_msg = 8'h3C;
        pat = {10'd0, 3'b101, 8'h3C, 3'b101, 8'h81};
        watch("hold", pat, 22, 32'h0000_0442, 8'h81, 1'b0, 0);
        @(negedge clk);
        chk_idle("hold_after");

        // Reset during DATA cnt=4 of 8'hC3 truncates the frame at once.
        in_val = 1'b1;
        in_msg = 8'hC3;
        pat = {24'd0, 3'b101, 5'b11000};
        watch("trunc", pat, 8, 32'h0, 8'h00, 1'b0, 0);
        reset = 1'b1;
        #2;
        chk("trunc.rst_out",     {31'd0, out},     32'd0);
        chk("trunc.rst_out_val", {31'd0, out_val}, 32'd0);
        chk("trunc.rst_busy",    {31'd0, busy},    32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_idle("post_rst");
        in_val = 1'b1;
        in_msg = 8'h5A;
        pat = {21'd0, 3'b101, 8'h5A};
        watch("post_rst_frame", pat, 11, 32'h0, 8'h00, 1'b0, 0);
        @(negedge clk);
        chk_idle("post_rst_after");

        // Loopback into the detector: one hit, in the cycle after SYNC2.
        in_val = 1'b1;
        in_msg = 8'h00;
        pat = {21'd0, 3'b101, 8'h00};
        watch("loop", pat, 11, 32'h0, 8'h00, 1'b1, 3);
        @(negedge clk);
        chk_idle("loop_after");
        chk("loop.det_after", {31'd0, det_out}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_fsm_101_frame_tx
`default_nettype wire
